// File: rtl/prog_loader.sv
// Boot-time program loader: receives a sync/length/payload/checksum frame, writes the
// payload into instruction memory and releases the CPU reset only after the checksum passes.
module prog_loader #(
    parameter int ADDR_W     = 8,
    parameter int RESET_HOLD = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic              err
);

    // state  | meaning
    // IDLE   | waiting for sync byte, other bytes dropped
    // LEN    | waiting for length byte
    // DATA   | writing payload bytes to memory
    // CSUM   | waiting for checksum byte
    // HOLD   | checksum good, CPU held for RESET_HOLD+1 cycles, input stalled
    // RUN    | CPU released; sync byte starts a reload
    // ERR    | checksum bad; sync byte starts a new frame
    typedef enum logic [2:0] {
        S_IDLE, S_LEN, S_DATA, S_CSUM, S_HOLD, S_RUN, S_ERR
    } state_t;

    localparam logic [7:0] SYNC   = 8'hA5;
    localparam int         HOLD_W = $clog2(RESET_HOLD + 1);

    state_t              state;
    logic [8:0]          remaining;
    logic [ADDR_W-1:0]   addr;
    logic [7:0]          sum;
    logic [7:0]          csum_total;
    logic [HOLD_W-1:0]   hold_cnt;
    logic                accept;
    logic                sync_acc;

    assign in_ready   = (state != S_HOLD);
    assign accept     = in_valid && in_ready;
    assign sync_acc   = accept && (in_data == SYNC);
    assign csum_total = sum + in_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            remaining <= '0;
            addr      <= '0;
            sum       <= '0;
            hold_cnt  <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_rst   <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (sync_acc) begin
                        state <= S_LEN;
                        busy  <= 1'b1;
                    end
                end
                S_LEN: begin
                    if (accept) begin
                        // length byte 0 encodes a full 256-byte payload
                        remaining <= (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
                        addr      <= '0;
                        sum       <= '0;
                        state     <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= addr;
                        mem_wdata <= in_data;
                        addr      <= addr + 1'b1;
                        sum       <= csum_total;
                        remaining <= remaining - 9'd1;
                        if (remaining == 9'd1)
                            state <= S_CSUM;
                    end
                end
                S_CSUM: begin
                    if (accept) begin
                        busy <= 1'b0;
                        if (csum_total == 8'd0) begin
                            hold_cnt <= RESET_HOLD[HOLD_W-1:0];
                            state    <= S_HOLD;
                        end else begin
                            err   <= 1'b1;
                            state <= S_ERR;
                        end
                    end
                end
                S_HOLD: begin
                    if (hold_cnt == '0) begin
                        state   <= S_RUN;
                        cpu_rst <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end
                end
                S_RUN: begin
                    if (sync_acc) begin
                        state   <= S_LEN;
                        cpu_rst <= 1'b1;
                        done    <= 1'b0;
                        busy    <= 1'b1;
                    end
                end
                S_ERR: begin
                    if (sync_acc) begin
                        state <= S_LEN;
                        err   <= 1'b0;
                        busy  <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
